// File: rtl/skid_reg.sv
// Two-entry valid/ready skid buffer. Every output is decoded from registers,
// so no combinational path runs from in_* to out_* or from out_ready to in_ready.
module skid_reg #(
  parameter int n = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         in_valid,
  input  logic [n-1:0] in_data,
  output logic         in_ready,
  output logic         out_valid,
  output logic [n-1:0] out_data,
  input  logic         out_ready,
  output logic [1:0]   occupancy
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t       state, state_nxt;
  logic [n-1:0] main_q, skid_q;
  logic         live_q;  // low from reset assertion until the first edge after release
  logic         in_fire, out_fire;
  logic         load_main_in, load_main_skid, load_skid;

  assign in_fire  = in_valid & in_ready;
  assign out_fire = out_valid & out_ready;

  // NOTE: every signal written here gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_nxt      = state;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    if (flush) begin
      state_nxt = EMPTY;
    end else begin
      unique case (state)
        EMPTY: begin
          if (in_fire) begin
            load_main_in = 1'b1;
            state_nxt    = ONE;
          end
        end
        ONE: begin
          if (in_fire && out_fire) begin
            load_main_in = 1'b1;
          end else if (in_fire) begin
            load_skid = 1'b1;
            state_nxt = FULL;
          end else if (out_fire) begin
            state_nxt = EMPTY;
          end
        end
        FULL: begin
          if (out_fire) begin
            load_main_skid = 1'b1;
            state_nxt      = ONE;
          end
        end
        default: state_nxt = EMPTY;
      endcase
    end
  end

  // NOTE: the data registers are reset too, because out_data must read 0 while rst_n is low.
  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= EMPTY;
      main_q <= '0;
      skid_q <= '0;
      live_q <= 1'b0;
    end else begin
      state  <= state_nxt;
      live_q <= 1'b1;
      if (load_main_in)        main_q <= in_data;
      else if (load_main_skid) main_q <= skid_q;
      if (load_skid)           skid_q <= in_data;
    end
  end

  assign out_valid = (state != EMPTY);
  assign in_ready  = live_q && (state != FULL);
  assign out_data  = main_q;

  always_comb begin
    occupancy = 2'd0;
    unique case (state)
      ONE:     occupancy = 2'd1;
      FULL:    occupancy = 2'd2;
      default: occupancy = 2'd0;
    endcase
  end

endmodule

// File: tb/tb_skid_reg.sv
// Directed bench for skid_reg: the driver pushes expected words into a queue,
// a negedge monitor pops and compares on every output handshake.
module tb_skid_reg;

  localparam int N = 32;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         flush;
  logic         in_valid;
  logic [N-1:0] in_data;
  logic         in_ready;
  logic         out_valid;
  logic [N-1:0] out_data;
  logic         out_ready;
  logic [1:0]   occupancy;

  int checks = 0;
  int errors = 0;
  logic [N-1:0] sb_q[$];

  skid_reg #(.n(N)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .occupancy (occupancy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Advance one rising edge; inputs change and outputs are sampled 1ns after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [N-1:0] d, input logic r, input logic f);
    in_valid  = v;
    in_data   = d;
    out_ready = r;
    flush     = f;
  endtask

  task automatic check_ctl(input string tag, input logic [1:0] occ, input logic ir, input logic ov);
    check({tag, ".occupancy"}, N'(occupancy), N'(occ));
    check({tag, ".in_ready"},  N'(in_ready),  N'(ir));
    check({tag, ".out_valid"}, N'(out_valid), N'(ov));
  endtask

  // Monitor: out_fire happens at the coming rising edge, so compare now.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output: got 0x%08h expected no word at %0t", out_data, $time);
      end else begin
        check("out_word", out_data, sb_q.pop_front());
      end
    end
  end

  initial begin
    #20000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    drive(1'b0, '0, 1'b0, 1'b0);

    // Reset/idle
    step();
    check_ctl("rst", 2'd0, 1'b0, 1'b0);
    check("rst.out_data", out_data, '0);
    step();
    rst_n = 1'b1;
    #1;
    check("release.in_ready_before_edge", N'(in_ready), N'(1'b0));
    step();
    check_ctl("idle", 2'd0, 1'b1, 1'b0);

    // Streaming at full throughput
    drive(1'b1, 32'h0000_00AA, 1'b1, 1'b0); sb_q.push_back(32'h0000_00AA); step();
    check_ctl("stream0", 2'd1, 1'b1, 1'b1);
    check("stream0.out_data", out_data, 32'h0000_00AA);
    drive(1'b1, 32'h0000_0055, 1'b1, 1'b0); sb_q.push_back(32'h0000_0055); step();
    check_ctl("stream1", 2'd1, 1'b1, 1'b1);
    check("stream1.out_data", out_data, 32'h0000_0055);
    drive(1'b1, 32'h0000_00F0, 1'b1, 1'b0); sb_q.push_back(32'h0000_00F0); step();
    check_ctl("stream2", 2'd1, 1'b1, 1'b1);
    check("stream2.out_data", out_data, 32'h0000_00F0);
    drive(1'b0, '0, 1'b1, 1'b0); step();
    check_ctl("stream_drain", 2'd0, 1'b1, 1'b0);

    // Backpressure
    drive(1'b1, 32'h0000_00CC, 1'b0, 1'b0); sb_q.push_back(32'h0000_00CC); step();
    check_ctl("bp0", 2'd1, 1'b1, 1'b1);
    drive(1'b1, 32'h0000_0033, 1'b0, 1'b0); sb_q.push_back(32'h0000_0033); step();
    check_ctl("bp1", 2'd2, 1'b0, 1'b1);
    check("bp1.out_data", out_data, 32'h0000_00CC);

    // Held input while FULL is ignored and the head stays stable
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0); step();
      check_ctl("full_hold", 2'd2, 1'b0, 1'b1);
      check("full_hold.out_data", out_data, 32'h0000_00CC);
    end

    drive(1'b0, '0, 1'b1, 1'b0); step();
    check_ctl("bp_pop0", 2'd1, 1'b1, 1'b1);
    check("bp_pop0.out_data", out_data, 32'h0000_0033);
    step();
    check_ctl("bp_pop1", 2'd0, 1'b1, 1'b0);

    // Flush while FULL, with a word offered
    drive(1'b1, 32'h0000_0011, 1'b0, 1'b0); step();
    drive(1'b1, 32'h0000_0022, 1'b0, 1'b0); step();
    check_ctl("pre_flush", 2'd2, 1'b0, 1'b1);
    drive(1'b1, 32'h1234_5678, 1'b0, 1'b1); step();
    check_ctl("flush_full", 2'd0, 1'b1, 1'b0);

    // Flush while ONE: the simultaneous in_fire must be discarded
    drive(1'b1, 32'h0000_0044, 1'b0, 1'b0); step();
    check_ctl("pre_flush1", 2'd1, 1'b1, 1'b1);
    drive(1'b1, 32'h1234_5678, 1'b0, 1'b1); step();
    check_ctl("flush_one", 2'd0, 1'b1, 1'b0);
    drive(1'b0, '0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step();
      check_ctl("post_flush", 2'd0, 1'b1, 1'b0);
    end

    // Asynchronous reset between edges while FULL
    drive(1'b1, 32'h0000_55AA, 1'b0, 1'b0); step();
    drive(1'b1, 32'h0000_66BB, 1'b0, 1'b0); step();
    check_ctl("pre_reset", 2'd2, 1'b0, 1'b1);
    drive(1'b0, '0, 1'b0, 1'b0);
    #1 rst_n = 1'b0;
    #1;
    check_ctl("async_rst", 2'd0, 1'b0, 1'b0);
    check("async_rst.out_data", out_data, '0);
    #1 rst_n = 1'b1;
    step();
    check_ctl("post_rst", 2'd0, 1'b1, 1'b0);
    drive(1'b1, 32'hA5A5_A5A5, 1'b1, 1'b0); sb_q.push_back(32'hA5A5_A5A5); step();
    check_ctl("post_rst_word", 2'd1, 1'b1, 1'b1);
    check("post_rst_word.out_data", out_data, 32'hA5A5_A5A5);
    drive(1'b0, '0, 1'b1, 1'b0);
    step();
    step();
    check_ctl("final_idle", 2'd0, 1'b1, 1'b0);
    check("scoreboard_empty", N'(sb_q.size()), '0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/skid_reg.md
Name: skid_reg

Overview:
- Two-entry valid/ready pipeline register (skid buffer) that sits directly downstream of mux2.
- Captures the selected mux2 output C and presents it to the next datapath stage one cycle later.
- Absorbs one-cycle backpressure without dropping data.
- Breaks every combinational path between upstream and downstream, so no combinational in->out or out_ready->in_ready timing path exists.

Parameters:
n, 32, data width in bits; matches mux2 n.

Ports:
clk  input  1  system clock, rising-edge active
rst_n  input  1  asynchronous active-low reset
flush  input  1  synchronous clear; discards all held data
in_valid  input  1  upstream data valid (driven alongside mux2 C)
in_data  input  n  upstream data (mux2 C)
in_ready  output  1  block can accept in_data this cycle
out_valid  output  1  out_data holds valid data
out_data  output  n  oldest held word
out_ready  input  1  downstream accepts out_data this cycle
occupancy  output  2  number of held words, 0..2

Behaviour:
- Reset: one clock, clk; reset is asynchronous, active-low (rst_n).
- While rst_n=0, outputs are forced immediately, independent of clk:
  - state=EMPTY
  - main and skid registers = 0
  - out_valid=0, out_data=0, occupancy=0, in_ready=0
- Deassertion of rst_n takes effect at the next rising edge. From then on in_ready=1 (state EMPTY).
- Handshakes: in_fire = in_valid & in_ready; out_fire = out_valid & out_ready. Both are sampled at the rising edge of clk.
- Storage: main register (head, drives out_data) and skid register (second entry).
- State machine: EMPTY (0 words), ONE (main valid), FULL (main+skid valid).
- All outputs are decoded from registered state only:
  - out_valid = (state != EMPTY)
  - in_ready = (state != FULL) and not in reset
  - occupancy = 0/1/2 for EMPTY/ONE/FULL
  - out_data = main
- Transitions, evaluated only when flush=0:
  - EMPTY, in_fire: main <= in_data, go to ONE. Otherwise hold.
  - ONE, in_fire & out_fire: main <= in_data, stay ONE.
  - ONE, in_fire only: skid <= in_data, go to FULL.
  - ONE, out_fire only: go to EMPTY.
  - ONE, neither: hold.
  - FULL: in_ready=0, so in_valid is ignored. On out_fire: main <= skid, go to ONE. Otherwise hold.
- Latency: a word accepted at edge k is visible on out_data after edge k, i.e. one cycle. Throughput is 1 word/cycle when out_ready is held 1.
- Ordering is strict FIFO. No word is duplicated or dropped except by flush or reset.
- Stability: while out_valid=1 and out_ready=0, out_data and out_valid must not change.
- flush=1 at an edge:
  - state <= EMPTY.
  - An in_fire in the same cycle is discarded.
  - An out_fire in the same cycle still counts as consumed downstream; the block takes no extra action.
  - flush has priority over all transitions.
  - main/skid contents after flush are don't-care but must not appear with out_valid=1.
- Reset asserted mid-transfer: all held words are lost immediately and outputs take reset values within the same cycle.
- Values beyond n bits do not exist; widths are fixed at n. No arithmetic is performed.

Test Plan:
- Reset/idle: hold rst_n=0 for 2 cycles, then release -> during reset out_valid=0, occupancy=0, in_ready=0. After the first edge in_ready=1, out_valid=0.
- Streaming: out_ready=1; in_valid=1 with in_data 0x000000AA, 0x00000055, 0x000000F0 on consecutive cycles -> out_data shows AA, 55, F0 one cycle later each, occupancy stays 1, in_ready stays 1.
- Backpressure: out_ready=0; send 0x000000CC then 0x00000033 -> occupancy 1 then 2, in_ready=0 after the second word, and out_data holds CC. Then set out_ready=1 -> CC, then 33 on successive cycles; in_ready returns to 1 after the first out_fire.
- Held input while FULL: block is FULL; drive in_valid=1 with 0xDEADBEEF for 3 cycles and out_ready=0 -> nothing is accepted, occupancy stays 2, out_data unchanged.
- Flush: block is FULL; assert flush with in_valid=1 and in_data 0x12345678 -> next cycle out_valid=0, occupancy=0, in_ready=1, and 0x12345678 is never output.
- Async reset mid-operation: block is FULL; pulse rst_n low between clock edges -> out_valid, occupancy and out_data go to 0 immediately without waiting for clk. After release, the next word sent is the first and only word output.
